// File: rtl/slant_link_rx_if.sv
// rtl/slant_link_rx_if.sv - lane symbol input and pixel write output bundle for slant_link_rx
interface slant_link_rx_if;
  // Link side: one strobe qualifies all four lane symbols
  logic        RecValid;
  logic [5:0]  Rec0Data;
  logic [5:0]  Rec1Data;
  logic [5:0]  Rec2Data;
  logic [5:0]  Rec3Data;

  // Frame store side: pixel pair writes and link status
  logic        PixWrEn;
  logic [15:0] PixWrAddr;
  logic [19:0] PixYData;
  logic [19:0] PixCData;
  logic        FrameStart;
  logic        FrameId;
  logic        FrameDone;
  logic        Locked;
  logic        SyncErr;
  logic [11:0] RxLineCount;
  logic [15:0] SyncErrCount;
  logic [15:0] DataErrCount;

  // Symbol source (link PHY or bench)
  modport master (
    output RecValid, Rec0Data, Rec1Data, Rec2Data, Rec3Data,
    input  PixWrEn, PixWrAddr, PixYData, PixCData,
    input  FrameStart, FrameId, FrameDone, Locked, SyncErr,
    input  RxLineCount, SyncErrCount, DataErrCount
  );

  // Receiver
  modport slave (
    input  RecValid, Rec0Data, Rec1Data, Rec2Data, Rec3Data,
    output PixWrEn, PixWrAddr, PixYData, PixCData,
    output FrameStart, FrameId, FrameDone, Locked, SyncErr,
    output RxLineCount, SyncErrCount, DataErrCount
  );
endinterface

// File: rtl/slant_link_rx.sv
// rtl/slant_link_rx.sv - 4-lane slant link receiver: frame hunt, Y/C pair demux, line-header check
// Optional error statistics counters are built when SLANT_RX_STATS_EN is defined.
module slant_link_rx #(
  parameter int          LINE_SYMS = 160,
  parameter int          LINES     = 480,
  parameter logic [23:0] FRAME1    = 24'haab155,
  parameter logic [23:0] FRAME0    = 24'haa8d55,
  parameter logic [7:0]  HSYNC     = 8'h55
) (
  input  logic           Cclk,
  input  logic           rst,
  slant_link_rx_if.slave rx
);

  localparam logic [7:0]  K_LAST  = 8'(LINE_SYMS - 1);
  localparam logic [11:0] LINES_L = 12'(LINES);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_DATA  = 2'd1,
    S_LSYNC = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] mark_sr_q, mark_sr_d;
  logic [7:0]  k_q, k_d;
  logic [15:0] addr_q, addr_d;
  logic [11:0] line_q, line_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic [6:0]  hpat_q, hpat_d;
  logic [19:0] y_q, y_d;

  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [19:0] pix_y_q, pix_y_d;
  logic [19:0] pix_c_q, pix_c_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_id_q, frame_id_d;
  logic        frame_done_q, frame_done_d;
  logic        sync_err_q, sync_err_d;

  // Per-symbol decode: a marker symbol is 6'h3f on every lane; data uses the low 5 bits
  logic        mark;
  logic [23:0] mark_shift;
  logic        hdr_hit;
  logic [19:0] low5;

  assign mark = (rx.Rec0Data == 6'h3f) && (rx.Rec1Data == 6'h3f) &&
                (rx.Rec2Data == 6'h3f) && (rx.Rec3Data == 6'h3f);
  assign mark_shift = {mark_sr_q[22:0], mark};
  assign hdr_hit    = rx.RecValid && ((mark_shift == FRAME1) || (mark_shift == FRAME0));
  assign low5       = {rx.Rec3Data[4:0], rx.Rec2Data[4:0], rx.Rec1Data[4:0], rx.Rec0Data[4:0]};

  // Next-state and output decode; a frame header overrides every other event on its symbol
  always_comb begin
    state_d       = state_q;
    mark_sr_d     = mark_sr_q;
    k_d           = k_q;
    addr_d        = addr_q;
    line_d        = line_q;
    hcnt_d        = hcnt_q;
    hpat_d        = hpat_q;
    y_d           = y_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    pix_y_d       = pix_y_q;
    pix_c_d       = pix_c_q;
    frame_start_d = 1'b0;
    frame_id_d    = frame_id_q;
    frame_done_d  = 1'b0;
    sync_err_d    = 1'b0;

    if (rx.RecValid) begin
      mark_sr_d = mark_shift;
      if (hdr_hit) begin
        frame_start_d = 1'b1;
        frame_id_d    = (mark_shift == FRAME1);
        state_d       = S_DATA;
        k_d           = 8'd0;
        addr_d        = 16'd0;
        line_d        = 12'd0;
        mark_sr_d     = 24'd0;
      end else begin
        unique case (state_q)
          S_DATA: begin
            if (!k_q[0]) begin
              y_d = low5;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              pix_y_d   = y_q;
              pix_c_d   = low5;
              addr_d    = addr_q + 16'd1;
            end
            if (k_q == K_LAST) begin
              k_d    = 8'd0;
              line_d = line_q + 12'd1;
              if (line_q + 12'd1 == LINES_L) begin
                frame_done_d = 1'b1;
                state_d      = S_DONE;
              end else begin
                state_d = S_LSYNC;
                hcnt_d  = 3'd0;
                hpat_d  = 7'd0;
              end
            end else begin
              k_d = k_q + 8'd1;
            end
          end
          S_LSYNC: begin
            hpat_d = {hpat_q[5:0], mark};
            hcnt_d = hcnt_q + 3'd1;
            if (hcnt_q == 3'd7) begin
              if ({hpat_q, mark} == HSYNC) begin
                state_d = S_DATA;
                k_d     = 8'd0;
              end else begin
                sync_err_d = 1'b1;
                state_d    = S_HUNT;
              end
            end
          end
          S_HUNT, S_DONE: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State, counters, shift registers and registered output pulses
  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HUNT;
      mark_sr_q     <= 24'd0;
      k_q           <= 8'd0;
      addr_q        <= 16'd0;
      line_q        <= 12'd0;
      hcnt_q        <= 3'd0;
      hpat_q        <= 7'd0;
      y_q           <= 20'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 16'd0;
      pix_y_q       <= 20'd0;
      pix_c_q       <= 20'd0;
      frame_start_q <= 1'b0;
      frame_id_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mark_sr_q     <= mark_sr_d;
      k_q           <= k_d;
      addr_q        <= addr_d;
      line_q        <= line_d;
      hcnt_q        <= hcnt_d;
      hpat_q        <= hpat_d;
      y_q           <= y_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      pix_y_q       <= pix_y_d;
      pix_c_q       <= pix_c_d;
      frame_start_q <= frame_start_d;
      frame_id_q    <= frame_id_d;
      frame_done_q  <= frame_done_d;
      sync_err_q    <= sync_err_d;
    end
  end

`ifdef SLANT_RX_STATS_EN
  logic [15:0] sync_cnt_q, sync_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;
  logic        data_err_ev;

  // A data error is a non-header DATA symbol with bit5 set on any lane
  assign data_err_ev = rx.RecValid && !hdr_hit && (state_q == S_DATA) &&
                       (rx.Rec0Data[5] | rx.Rec1Data[5] | rx.Rec2Data[5] | rx.Rec3Data[5]);

  // Saturating error counters
  always_comb begin
    sync_cnt_d = sync_cnt_q;
    data_cnt_d = data_cnt_q;
    if (sync_err_d && (sync_cnt_q != 16'hffff)) begin
      sync_cnt_d = sync_cnt_q + 16'd1;
    end
    if (data_err_ev && (data_cnt_q != 16'hffff)) begin
      data_cnt_d = data_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge Cclk or posedge rst) begin
    if (rst) begin
      sync_cnt_q <= 16'd0;
      data_cnt_q <= 16'd0;
    end else begin
      sync_cnt_q <= sync_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  assign rx.SyncErrCount = sync_cnt_q;
  assign rx.DataErrCount = data_cnt_q;
`else
  assign rx.SyncErrCount = 16'h0000;
  assign rx.DataErrCount = 16'h0000;
`endif

  assign rx.PixWrEn     = wr_en_q;
  assign rx.PixWrAddr   = wr_addr_q;
  assign rx.PixYData    = pix_y_q;
  assign rx.PixCData    = pix_c_q;
  assign rx.FrameStart  = frame_start_q;
  assign rx.FrameId     = frame_id_q;
  assign rx.FrameDone   = frame_done_q;
  assign rx.Locked      = (state_q == S_DATA) || (state_q == S_LSYNC);
  assign rx.SyncErr     = sync_err_q;
  assign rx.RxLineCount = line_q;

endmodule

// File: doc/slant_link_rx.md
Name: slant_link_rx

Overview:
- Receive side of the 4-lane slant video link; decodes the symbol stream the Tx-side frame store emits.
- Hunts for the 24-symbol frame header, then demultiplexes alternating Y/C data symbols into per-lane 5-bit pixel pairs.
- Checks the 8-symbol line header after each line.
- Produces a write stream (address, 4xY, 4xC) for the Rx-side frame store / HDMI path.

Parameters:
- LINE_SYMS, 160, data symbols per line per lane (Y,C alternating; 80 pixel pairs).
- LINES, 480, lines per frame.
- FRAME1, 24'haab155, header bit pattern, frame id 1.
- FRAME0, 24'haa8d55, header bit pattern, frame id 0.
- HSYNC, 8'h55, line header bit pattern.

Ports:
- Cclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RecValid  in  1  one-cycle strobe; lane inputs are valid when RecValid=1.
- Rec0Data..Rec3Data  in  6 each  lane symbols.
- PixWrEn  out  1  one-cycle write strobe.
- PixWrAddr  out  16  pair address, 0..(LINE_SYMS/2*LINES-1).
- PixYData  out  20  {Y3,Y2,Y1,Y0}, 5 bits each.
- PixCData  out  20  {C3,C2,C1,C0}.
- FrameStart  out  1  pulse on header match.
- FrameId  out  1  1=FRAME1, 0=FRAME0; held until the next header.
- FrameDone  out  1  pulse after the last pair of line LINES-1.
- Locked  out  1  high in the DATA and LSYNC states.
- SyncErr  out  1  pulse on a line-header mismatch.
- RxLineCount  out  12  completed lines in the current frame.
- SyncErrCount  out  16  see Optional Feature.
- DataErrCount  out  16  see Optional Feature.

Behaviour:
- Reset: all outputs 0; state HUNT; all counters and shift registers 0.
- Only cycles with RecValid=1 advance any state. Gaps of any length between strobes are legal.
- Marker bit per symbol: 1 if all four lanes == 6'h3f, else 0. It is shifted into a 24-bit MarkSR (new bit in the LSB) on every valid symbol, in every state.
- Frame header check runs in any state:
  - Trigger: MarkSR, including the current symbol, == FRAME1 or FRAME0.
  - Next cycle: FrameStart=1 and FrameId set.
  - State -> DATA; symbol count, pair address and RxLineCount -> 0; MarkSR cleared.
  - A header takes priority over every other event on the same symbol.
- State HUNT: ignore data; Locked=0.
- State DATA:
  - Symbol index k counts 0..LINE_SYMS-1.
  - Even k: latch Rec[n][4:0] as Yn.
  - Odd k: the cycle after the strobe, PixWrEn=1, PixYData=latched Y, PixCData=Rec[n][4:0], PixWrAddr=pair counter; the pair counter then increments.
  - Any lane with bit5=1 in DATA: data error event; low 5 bits still used.
  - After k=LINE_SYMS-1: RxLineCount+1.
    - If RxLineCount reaches LINES: FrameDone pulse (same cycle as the final PixWrEn), state DONE.
    - Otherwise state LSYNC with a 3-bit header count cleared.
- State LSYNC:
  - Consume exactly 8 symbols, collecting marker bits MSB first.
  - On the 8th: if the pattern == HSYNC, state DATA with k=0 and the pair address continuing.
  - Else SyncErr pulse, state HUNT.
  - No writes in this state.
- State DONE: no writes; wait for a frame header.
- Pair address wraps only via a frame header. Writes after DONE are never produced.
- Reset asserted mid-frame: immediate return to the reset state, no partial write.
- Output pulses are one Cclk wide and registered. Write latency is 1 cycle from the C-symbol strobe.

Optional Feature:
- Macro SLANT_RX_STATS_EN.
- Defined: SyncErrCount increments on each SyncErr. DataErrCount increments on each DATA symbol with any bit5 set. Both saturate at 16'hffff and are cleared only by rst.
- Undefined: both ports tied to 16'h0000 and no counter logic is built.

Test Plan:
- Reset, FRAME1 header (24 symbols), then 160 data symbols with Y=k, C=k+1 on all lanes: FrameStart, FrameId=1, 80 writes at addr 0..79, first write Y=5'h00 C=5'h01, RxLineCount=1.
- Continue with an 8-symbol 0x55 header and a second line: Locked stays 1, SyncErr=0, writes resume at addr 80.
- Line header 0x54 instead of 0x55: SyncErr pulse, Locked=0, no writes until the next FRAME0 header. Then FrameId=0 and the address restarts at 0.
- Full frame of 480 lines: 38400 writes, last addr 38399, FrameDone coincident with the last PixWrEn, state DONE. Extra data symbols cause no writes.
- FRAME0 header inserted mid-line with random RecValid gaps (0-7 cycles): restart at addr 0, RxLineCount=0, write values unaffected by the gaps.
- With SLANT_RX_STATS_EN: 3 bad line headers and 5 bit5-set data symbols give SyncErrCount=3, DataErrCount=5. rst asserted mid-line clears every output within the reset cycle.
